// File: rtl/shader_program_ctrl.sv
// Instruction-store sequencer for the tiny shader: streams a DEPTH-entry circular program
// to the core and defers SPI loads that arrive mid-run. Optional macro: SHADER_CTRL_OVF_FLAG_EN.
module shader_program_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] instr_i,
  input  logic       start_i,
  input  logic       advance_i,
  output logic [7:0] instr_o,
  output logic       instr_valid_o,
  output logic       last_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       overflow_o
);
  localparam int PC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(DEPTH - 1);

  typedef logic [DEPTH-1:0][7:0] mem_t;
  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  mem_t            mem_q;
  logic [PC_W-1:0] pc_q;
  logic            pend_vld_q;
  logic [7:0]      pend_data_q;
  logic            start_pend_q;
  logic            done_q;

  function automatic mem_t shift_in(input mem_t m, input logic [7:0] d);
    return {d, m[DEPTH-1:1]};
  endfunction

  function automatic mem_t rotate(input mem_t m);
    return {m[0], m[DEPTH-1:1]};
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mem_q        <= '0;
      pc_q         <= '0;
      pend_vld_q   <= 1'b0;
      pend_data_q  <= 8'h00;
      start_pend_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A deferred load always drains before a run may begin.
          if (pend_vld_q) begin
            mem_q      <= shift_in(mem_q, pend_data_q);
            pend_vld_q <= load_i;
            if (load_i) pend_data_q <= instr_i;
            if (start_i) start_pend_q <= 1'b1;
          end else if (start_i || start_pend_q) begin
            state_q      <= RUN;
            pc_q         <= '0;
            start_pend_q <= 1'b0;
            if (load_i) begin
              pend_vld_q  <= 1'b1;
              pend_data_q <= instr_i;
            end
          end else if (load_i) begin
            mem_q <= shift_in(mem_q, instr_i);
          end
        end
        RUN: begin
          if (advance_i) begin
            mem_q <= rotate(mem_q);
            if (pc_q == PC_LAST) begin
              state_q <= IDLE;
              pc_q    <= '0;
              done_q  <= 1'b1;
            end else begin
              pc_q <= pc_q + PC_W'(1);
            end
          end
          if (load_i && !pend_vld_q) begin
            pend_vld_q  <= 1'b1;
            pend_data_q <= instr_i;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SHADER_CTRL_OVF_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if ((state_q == RUN) && load_i && pend_vld_q) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow_o = ovf_q;
`else
  assign overflow_o = 1'b0;
`endif

  assign instr_o       = mem_q[0];
  assign instr_valid_o = (state_q == RUN);
  assign last_o        = (state_q == RUN) && (pc_q == PC_LAST);
  assign busy_o        = (state_q == RUN) || pend_vld_q || start_pend_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_shader_program_ctrl.sv
// Directed bench for shader_program_ctrl: a queue model of the instruction memory feeds a
// scoreboard of expected instructions that is drained as the core advances.
module tb_shader_program_ctrl;
  localparam int DEPTH = 8;
`ifdef SHADER_CTRL_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       load_i = 1'b0;
  logic [7:0] instr_i = 8'h00;
  logic       start_i = 1'b0;
  logic       advance_i = 1'b0;
  logic [7:0] instr_o;
  logic       instr_valid_o;
  logic       last_o;
  logic       busy_o;
  logic       done_o;
  logic       overflow_o;

  shader_program_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(load_i), .instr_i(instr_i),
    .start_i(start_i), .advance_i(advance_i), .instr_o(instr_o),
    .instr_valid_o(instr_valid_o), .last_o(last_o), .busy_o(busy_o),
    .done_o(done_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int         total = 0;
  int         bad = 0;
  logic [7:0] model[$];
  logic [7:0] sb[$];
  bit         tb_pend = 1'b0;
  logic [7:0] tb_pend_d = 8'h00;
  logic       ovf_exp = 1'b0;
  int         cyc;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    model.delete();
    sb.delete();
    for (int i = 0; i < DEPTH; i++) model.push_back(8'h00);
    tb_pend = 1'b0;
    ovf_exp = 1'b0;
  endtask

  task automatic load(input logic [7:0] d);
    load_i  = 1'b1;
    instr_i = d;
    tick();
    load_i = 1'b0;
    model.push_back(d);
    void'(model.pop_front());
    chk("load_head", instr_o, model[0]);
    chk("load_busy", busy_o, 0);
  endtask

  task automatic start_run();
    sb = model;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Drains one run; returns in the done_o cycle with cyc counted from the start pulse.
  task automatic consume(input int stall_at, input int stall_len,
                         input int ld_at, input logic [7:0] ld_d,
                         input int ld2_at, input logic [7:0] ld2_d,
                         input int st_at, output int cyc_o);
    int idx = 0;
    int stalled = 0;
    bit adv;
    cyc_o = 1;
    chk("valid_at_start", instr_valid_o, 1);
    for (int n = 0; n < 200; n++) begin
      if (!instr_valid_o) break;
      chk("instr", instr_o, sb[0]);
      chk("last", last_o, sb.size() == 1);
      chk("busy_run", busy_o, 1);
      chk("done_in_run", done_o, 0);
      if (idx == stall_at && stalled < stall_len) begin
        adv = 1'b0;
        stalled++;
      end else begin
        adv = 1'b1;
      end
      advance_i = adv;
      load_i    = adv && (idx == ld_at || idx == ld2_at);
      instr_i   = (idx == ld_at) ? ld_d : ld2_d;
      start_i   = adv && (idx == st_at);
      if (load_i) begin
        if (!tb_pend) begin
          tb_pend   = 1'b1;
          tb_pend_d = instr_i;
        end else if (OVF_EN) begin
          ovf_exp = 1'b1;
        end
      end
      tick();
      advance_i = 1'b0;
      load_i    = 1'b0;
      start_i   = 1'b0;
      if (adv) begin
        void'(sb.pop_front());
        idx++;
      end
      cyc_o++;
    end
    chk("done", done_o, 1);
    chk("valid_off", instr_valid_o, 0);
    chk("last_off", last_o, 0);
    chk("sb_empty", sb.size(), 0);
    chk("overflow", overflow_o, ovf_exp);
  endtask

  task automatic apply_pend_model();
    if (tb_pend) begin
      model.push_back(tb_pend_d);
      void'(model.pop_front());
      tb_pend = 1'b0;
    end
  endtask

  task automatic finish_idle();
    chk("busy_done_cycle", busy_o, tb_pend);
    apply_pend_model();
    tick();
    chk("busy_after", busy_o, 0);
    chk("done_pulse_end", done_o, 0);
    chk("valid_idle", instr_valid_o, 0);
    chk("head_idle", instr_o, model[0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    reset_model();
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_instr", instr_o, 8'h00);

    // Program 0x01..0x08
    for (int i = 1; i <= DEPTH; i++) load(8'(i));
    chk("head_first_loaded", instr_o, 8'h01);

    // Basic run and replay
    start_run();
    consume(-1, 0, -1, 8'h00, -1, 8'h00, -1, cyc);
    chk("done_latency", cyc, DEPTH + 1);
    finish_idle();
    start_run();
    consume(-1, 0, -1, 8'h00, -1, 8'h00, -1, cyc);
    chk("replay_latency", cyc, DEPTH + 1);
    finish_idle();

    // Stall on 0x04 for 3 cycles; a start mid-run must be ignored
    start_run();
    consume(3, 3, -1, 8'h00, -1, 8'h00, 5, cyc);
    chk("stall_latency", cyc, DEPTH + 4);
    finish_idle();

    // Deferred load mid-run, then the next run shows it at the tail
    start_run();
    consume(-1, 0, 2, 8'hAA, -1, 8'h00, -1, cyc);
    finish_idle();
    chk("deferred_head", instr_o, 8'h02);
    start_run();
    consume(-1, 0, -1, 8'h00, -1, 8'h00, -1, cyc);
    finish_idle();

    // Two loads in one run: second dropped
    start_run();
    consume(-1, 0, 1, 8'hAA, 4, 8'hBB, -1, cyc);
    finish_idle();
    chk("ovf_sticky", overflow_o, ovf_exp);
    start_run();
    consume(-1, 0, -1, 8'h00, -1, 8'h00, -1, cyc);
    chk("ovf_tail", model[DEPTH-1], 8'hAA);
    finish_idle();

    // Start in the cycle the pending load is applied
    start_run();
    consume(-1, 0, 1, 8'hCC, -1, 8'h00, -1, cyc);
    chk("chain_busy", busy_o, 1);
    apply_pend_model();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("chain_valid_t1", instr_valid_o, 0);
    chk("chain_busy_t1", busy_o, 1);
    sb = model;
    tick();
    chk("chain_tail_cc", sb[DEPTH-1], 8'hCC);
    consume(-1, 0, -1, 8'h00, -1, 8'h00, -1, cyc);
    finish_idle();

    // Reset at the third instruction
    start_run();
    for (int i = 0; i < 2; i++) begin
      chk("pre_rst_instr", instr_o, sb[0]);
      advance_i = 1'b1;
      tick();
      void'(sb.pop_front());
    end
    chk("rst_mid_third", instr_o, sb[0]);
    rst_i = 1'b1;
    tick();
    rst_i     = 1'b0;
    advance_i = 1'b0;
    reset_model();
    chk("midrst_valid", instr_valid_o, 0);
    chk("midrst_instr", instr_o, 8'h00);
    chk("midrst_done", done_o, 0);
    chk("midrst_ovf", overflow_o, 0);
    chk("midrst_busy", busy_o, 0);
    tick();
    chk("midrst_no_done", done_o, 0);
    chk("midrst_idle", instr_valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
